byte_serial_subtractor_32: RTL and testbench
============================================

Name: byte_serial_subtractor_32

Overview:
- Multi-cycle 32-bit two's-complement subtractor: out = in1 - in2 - bin.
- Processes one byte per clock, least-significant byte first.
- Borrow ripples between bytes through a 1-bit register.
- Provides the subtract direction for the datapath where a single-cycle 32-bit ripple chain is too long. It exchanges area for latency behind a start/done handshake.

Parameters:
- none (width fixed at 32; byte lanes fixed at 4)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising edge when not in RUN
- in1  input  32  minuend; sampled with accepted start
- in2  input  32  subtrahend; sampled with accepted start
- bin  input  1  borrow-in; sampled with accepted start
- out  output  32  difference; registered; valid when done=1; held until next result
- bout  output  1  borrow-out: 1 iff unsigned in1 < in2 + bin
- ovf  output  1  signed overflow: (in1[31] != in2[31]) && (out[31] != in1[31])
- busy  output  1  1 while state is RUN or DONE
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; out=0, bout=0, ovf=0, busy=0, done=0.
  - Byte counter, operand registers and borrow register cleared.
  - A partial computation is discarded; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch in1, in2, bin into operand registers; count=0; borrow register=bin; go to RUN. start=0 -> stay.
  - RUN: each edge computes lane k=count:
    - {c, d} = a[8k+7:8k] + ~b[8k+7:8k] + ~borrow
    - result byte k = d; borrow = ~c
    - count increments.
    - At count=3, the edge writes out (all 4 bytes), bout=final borrow, ovf, and goes to DONE.
  - DONE: done=1, busy=1 for exactly one cycle.
    - Next edge with start=0 -> IDLE.
    - Next edge with start=1 -> accept new operands, go to RUN.
    - done falls either way.
- Latency: start sampled at edge t0 -> RUN t0..t4, out/bout/ovf/done updated at edge t4, done high t4..t5. Throughput is one result per 5 cycles when start is held high.
- start while in RUN is ignored. Operands are not resampled. The in-flight result is unaffected.
- Inputs may change freely after the accepting edge; only the latched copies are used.
- out/bout/ovf change only at the final RUN edge or on reset. Between results, the previous result is held stable.
- Arithmetic:
  - Modulo 2^32; wrap-around is silent in out.
  - Unsigned underflow is reported only via bout.
  - Signed overflow is reported only via ovf.
  - Both flags may be 1 simultaneously.
- bin=1 with in2=FFFFFFFF: the total subtrahend is 2^32. out=in1, bout=1 for every in1.
- busy=0 exactly in IDLE; done=1 implies busy=1.

Test Plan:
- Reset asserted mid-RUN (after 2 bytes, in1=0x12345678, in2=0x1): outputs immediately 0, busy=0. No done pulse follows. A subsequent start computes normally.
- in1=0x00000100, in2=0x00000001, bin=0 -> after 5 edges: out=0x000000FF, bout=0, ovf=0, done pulses exactly once. This checks the borrow across the byte0->byte1 lane.
- in1=0x00000000, in2=0x00000001, bin=0 -> out=0xFFFFFFFF, bout=1, ovf=0. in1=0x80000000, in2=0x00000001 -> out=0x7FFFFFFF, bout=0, ovf=1.
- in1=0x7FFFFFFF, in2=0xFFFFFFFF, bin=1 -> out=0x7FFFFFFF, bout=1, ovf=0. in1=0x00000005, in2=0x00000003, bin=1 -> out=0x00000001, bout=0.
- start held high continuously with operand pairs changing every cycle: only values present at accepting edges (t0, t5, t10, ...) are used. done pulses at t4, t9, t14. start pulses during RUN are ignored.
- 10k random operands with random bin -> out, bout and ovf match the reference model each done. out is stable between done pulses.

Source files
------------

// File: rtl/byte_serial_subtractor_32.sv
// Byte-serial 32-bit subtractor: out = in1 - in2 - bin, one byte lane per clock,
// LSB first, with the borrow carried between lanes in a 1-bit register.
module byte_serial_subtractor_32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic        bin,
   output logic [31:0] out,
   output logic        bout,
   output logic        ovf,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        borrow_q, borrow_d;
   logic [1:0]  count_q, count_d;
   logic [23:0] res_q, res_d;
   logic [31:0] out_q, out_d;
   logic        bout_q, bout_d;
   logic        ovf_q, ovf_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [4:0]  lane_lsb;
   logic [7:0]  lane_a, lane_b;
   logic [8:0]  lane_sum;

   // a - b - borrow == a + ~b + ~borrow; the lane carry-out is the inverted borrow.
   assign lane_lsb = {count_q, 3'b000};
   assign lane_a   = a_q[lane_lsb +: 8];
   assign lane_b   = b_q[lane_lsb +: 8];
   assign lane_sum = {1'b0, lane_a} + {1'b0, ~lane_b} + {8'd0, ~borrow_q};

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block can infer a latch.
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      count_d  = count_q;
      res_d    = res_q;
      out_d    = out_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = in1;
               b_d      = in2;
               borrow_d = bin;
               count_d  = 2'd0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         RUN: begin
            // Finished bytes shift in from the top, so after three lanes res_q = {b2, b1, b0}.
            res_d    = {lane_sum[7:0], res_q[23:8]};
            borrow_d = ~lane_sum[8];
            count_d  = count_q + 2'd1;
            if (count_q == 2'd3) begin
               out_d   = {lane_sum[7:0], res_q};
               bout_d  = ~lane_sum[8];
               ovf_d   = (a_q[31] != b_q[31]) && (lane_sum[7] != a_q[31]);
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments only; the async reset clears every
   // register so an interrupted operation leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         count_q  <= 2'd0;
         res_q    <= '0;
         out_q    <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         count_q  <= count_d;
         res_q    <= res_d;
         out_q    <= out_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign out  = out_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_byte_serial_subtractor_32.sv
// Self-checking bench: a transaction-level model predicts every output each cycle,
// plus directed literal cases, a mid-operation reset and a long random run.
module tb_byte_serial_subtractor_32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic        bin = 1'b0;
   logic [31:0] out;
   logic        bout, ovf, busy, done;

   int errors = 0;
   int checks = 0;

   byte_serial_subtractor_32 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .bin   (bin),
      .out   (out),
      .bout  (bout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the definition of the result and the flags.
   function automatic void model_calc(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                      output logic [31:0] o, output logic bo, output logic ov);
      longint s;
      o  = a - b - {31'd0, bi};
      bo = ({1'b0, a} < ({1'b0, b} + {32'd0, bi}));
      s  = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Transaction model: a request is taken whenever no operation is in flight, and its
   // result appears four edges later with a one-cycle done.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic        m_busy = 1'b0;
   logic [31:0] m_out = '0;
   logic        m_bout = 1'b0;
   logic        m_ovf = 1'b0;
   logic [31:0] p_out;
   logic        p_bout, p_ovf;
   int          m_results = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_busy = 1'b0;
         m_out = '0; m_bout = 1'b0; m_ovf = 1'b0;
      end else begin
         if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) begin
               m_out = p_out; m_bout = p_bout; m_ovf = p_ovf;
               m_results++;
            end
         end else begin
            m_done = 1'b0;
            if (start) begin
               model_calc(in1, in2, bin, p_out, p_bout, p_ovf);
               m_left = 4;
            end
         end
         m_busy = (m_left > 0) || m_done;
      end
   end

   always @(negedge clk) begin
      check("out",  out,          m_out);
      check("bout", {31'd0, bout}, {31'd0, m_bout});
      check("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
   end

   // One accepted operation from IDLE with literal expectations and latency check.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic bi, input logic [31:0] e_out, input logic e_bout,
                         input logic e_ovf);
      int lat;
      @(negedge clk);
      start = 1'b1; in1 = a; in2 = b; bin = bi;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start = 1'b0; in1 = $urandom; in2 = $urandom; bin = 1'($urandom);
         end
      end while (!done && lat < 12);
      check({name, "_latency"}, lat, 5);
      check({name, "_out"}, out, e_out);
      check({name, "_bout"}, {31'd0, bout}, {31'd0, e_bout});
      check({name, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
      @(negedge clk);
      check({name, "_done_once"}, {31'd0, done}, 32'd0);
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int dones;
      int cyc;
      logic [31:0] edge_vals [6];
      edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF;
      edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;
      edge_vals[4] = 32'h0000_0001; edge_vals[5] = 32'h0000_00FF;

      repeat (2) @(negedge clk);
      check("reset_out", out, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;

      run_op("byte_borrow", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
      run_op("underflow",   32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("signed_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      run_op("sub_2p32",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
      run_op("bin_one",     32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
      run_op("both_flags",  32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1);

      // Reset two lanes into an operation: outputs clear at once and no done follows.
      @(negedge clk);
      start = 1'b1; in1 = 32'h1234_5678; in2 = 32'h0000_0001; bin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out", out, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", dones, 0);
      run_op("after_rst",   32'h1234_5678, 32'h0000_0001, 1'b0, 32'h1234_5677, 1'b0, 1'b0);

      // start held high with operands changing every cycle: dones at t4, t9, t14.
      @(negedge clk);
      start = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         in1 = $urandom; in2 = $urandom; bin = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
      end
      check("held_start_dones", dones, 3);

      // Random run: start mostly high, operands mixing random and corner values.
      cyc = 0;
      while (m_results < 10010 && cyc < 70000) begin
         start = ($urandom_range(0, 9) != 0);
         in1 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         in2 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         bin = 1'($urandom);
         @(negedge clk);
         cyc++;
      end
      check("random_budget", {31'd0, (m_results >= 10010)}, 32'd1);
      start = 1'b0;
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
